// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl codes produced by the decoder and the
// execute-stage FSM state encoding. Also used by the decoder and branch logic.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1001;
    localparam logic [3:0] ALU_AND  = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } exec_state_t;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Operand/result handshake bundle of the ALU execute stage.
// master: the surrounding pipeline (drives operands, consumes result).
// slave : the execute stage itself.
interface alu_exec_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal_op;

    modport master (
        output in_valid, alu_ctrl, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal_op
    );

    modport slave (
        input  in_valid, alu_ctrl, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, illegal_op
    );
endinterface

// File: rtl/alu_shift_iter.sv
// Iterative shifter: one bit position per clock. The working register and
// counter are loaded on start; done is high in the cycle whose step is the
// last one, and data_out then carries the final shifted value.
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [XLEN-1:0]    data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               done,
    output logic [XLEN-1:0]    data_out
);

    logic [XLEN-1:0]    work_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic [3:0]         op_r;
    logic [XLEN-1:0]    step_s;

    // One-bit shift of the working register; SRA replicates the sign bit.
    always_comb begin
        step_s = work_r;
        case (op_r)
            ALU_SLL: step_s = {work_r[XLEN-2:0], 1'b0};
            ALU_SRL: step_s = {1'b0, work_r[XLEN-1:1]};
            ALU_SRA: step_s = {work_r[XLEN-1], work_r[XLEN-1:1]};
            default: step_s = work_r;
        endcase
    end

    // Working register / counter: load on start, then step until count is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r <= {XLEN{1'b0}};
            cnt_r  <= {SHAMT_W{1'b0}};
            op_r   <= 4'b0000;
        end else if (start) begin
            work_r <= data_in;
            cnt_r  <= shamt;
            op_r   <= op;
        end else if (cnt_r != {SHAMT_W{1'b0}}) begin
            work_r <= step_s;
            cnt_r  <= cnt_r - SHAMT_W'(1);
        end else begin
            work_r <= work_r;
            cnt_r  <= cnt_r;
        end
    end

    assign done     = (cnt_r == SHAMT_W'(1));
    assign data_out = step_s;

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: registered result, zero flag and illegal-op flag with
// valid/ready on both sides. Shifts run one bit per cycle in alu_shift_iter
// unless ALU_FAST_SHIFT_EN is defined, in which case a combinational barrel
// shifter gives every op a latency of one cycle.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_exec_stage_if.slave   bus
);

    localparam int SHAMT_W = $clog2(XLEN);

    exec_state_t        state_r;
    logic               out_valid_r;
    logic [XLEN-1:0]    result_r;
    logic               zero_r;
    logic               illegal_r;

    logic               in_ready_s;
    logic               accept_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic [XLEN-1:0]    issue_res_s;
    logic               issue_ill_s;
    logic               issue_shift_s;
    logic               shift_done_s;
    logic [XLEN-1:0]    shift_res_s;

    assign shamt_s  = bus.src_b[SHAMT_W-1:0];
    assign accept_s = bus.in_valid & in_ready_s;

    // Ready: free in IDLE, blocked while shifting, follows retire in DONE.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE:  in_ready_s = 1'b1;
            ST_SHIFT: in_ready_s = 1'b0;
            ST_DONE:  in_ready_s = bus.out_ready;
            default:  in_ready_s = 1'b0;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN
    logic [XLEN-1:0] fast_shift_s;

    // Barrel shifter for the single-cycle shift build.
    always_comb begin
        fast_shift_s = bus.src_a;
        case (bus.alu_ctrl)
            ALU_SLL: fast_shift_s = bus.src_a << shamt_s;
            ALU_SRL: fast_shift_s = bus.src_a >> shamt_s;
            ALU_SRA: fast_shift_s = $unsigned($signed(bus.src_a) >>> shamt_s);
            default: fast_shift_s = bus.src_a;
        endcase
    end

    assign shift_done_s = 1'b0;
    assign shift_res_s  = {XLEN{1'b0}};
`else
    alu_shift_iter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept_s & issue_shift_s),
        .op       (bus.alu_ctrl),
        .data_in  (bus.src_a),
        .shamt    (shamt_s),
        .done     (shift_done_s),
        .data_out (shift_res_s)
    );
`endif

    // Single-cycle datapath; non-zero shifts are handed to the iterative shifter.
    always_comb begin
        issue_res_s   = {XLEN{1'b0}};
        issue_ill_s   = 1'b0;
        issue_shift_s = 1'b0;
        case (bus.alu_ctrl)
            ALU_ADD:  issue_res_s = bus.src_a + bus.src_b;
            ALU_SUB:  issue_res_s = bus.src_a - bus.src_b;
            ALU_SLT:  issue_res_s = {{(XLEN-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
            ALU_SLTU: issue_res_s = {{(XLEN-1){1'b0}}, (bus.src_a < bus.src_b)};
            ALU_XOR:  issue_res_s = bus.src_a ^ bus.src_b;
            ALU_OR:   issue_res_s = bus.src_a | bus.src_b;
            ALU_AND:  issue_res_s = bus.src_a & bus.src_b;
            ALU_SLL, ALU_SRL, ALU_SRA: begin
`ifdef ALU_FAST_SHIFT_EN
                issue_res_s = fast_shift_s;
`else
                issue_res_s = bus.src_a;
                if (shamt_s != {SHAMT_W{1'b0}}) begin
                    issue_shift_s = 1'b1;
                end else begin
                    issue_shift_s = 1'b0;
                end
`endif
            end
            default: begin
                issue_res_s = {XLEN{1'b0}};
                issue_ill_s = 1'b1;
            end
        endcase
    end

    // Control FSM with registered result, flags and out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            zero_r      <= 1'b1;
            illegal_r   <= 1'b0;
        end else if (accept_s) begin
            // Accept is only possible in IDLE or on a DONE retire (back-to-back).
            if (issue_shift_s) begin
                state_r     <= ST_SHIFT;
                out_valid_r <= 1'b0;
            end else begin
                state_r     <= ST_DONE;
                out_valid_r <= 1'b1;
                result_r    <= issue_res_s;
                zero_r      <= (issue_res_s == {XLEN{1'b0}});
                illegal_r   <= issue_ill_s;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_SHIFT: begin
                    if (shift_done_s) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= shift_res_s;
                        zero_r      <= (shift_res_s == {XLEN{1'b0}});
                        illegal_r   <= 1'b0;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.result     = result_r;
    assign bus.zero       = zero_r;
    assign bus.illegal_op = illegal_r;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios followed by
// randomized traffic, checked every cycle against a transaction-level model
// (expected result per op plus a latency countdown).
module tb_alu_exec_stage;

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk;
    logic rst_n;

    alu_exec_stage_if #(.XLEN(32)) bus ();

    alu_exec_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    bit          exp_valid;
    logic [31:0] exp_res;
    bit          exp_ill;
    int          busy_cnt;
    logic [31:0] pend_res;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference ALU from the opcode table.
    function automatic void ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output bit ill);
        int sh;
        sh  = int'(b[4:0]);
        ill = 1'b0;
        case (c)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h3: r = a << sh;
            4'h4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h5: r = (a < b) ? 32'd1 : 32'd0;
            4'h6: r = a ^ b;
            4'h7: r = $unsigned($signed(a) >>> sh);
            4'h8: r = a >> sh;
            4'h9: r = a | b;
            4'hA: r = a & b;
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    function automatic int latency(input logic [3:0] c, input logic [31:0] b);
        bit is_sh;
        is_sh = (c == 4'h3) || (c == 4'h7) || (c == 4'h8);
        if (!FAST && is_sh && (b[4:0] != 5'd0)) return int'(b[4:0]) + 1;
        return 1;
    endfunction

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_res   = 32'd0;
        exp_ill   = 1'b0;
        busy_cnt  = 0;
        pend_res  = 32'd0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd1);
        check({tag, "_result"},    bus.result,             32'd0);
        check({tag, "_zero"},      {31'd0, bus.zero},      32'd1);
        check({tag, "_illegal"},   {31'd0, bus.illegal_op}, 32'd0);
    endtask

    // One clock: called at a negedge, drives inputs, checks, advances the model.
    task automatic step(input bit iv, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input bit ordy);
        bit          exp_rdy;
        bit          acc;
        bit          ret;
        logic [31:0] r;
        bit          ill;
        int          lat;
        bus.in_valid  = iv;
        bus.alu_ctrl  = c;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.out_ready = ordy;
        #1;
        exp_rdy = (busy_cnt == 0) && (!exp_valid || ordy);
        check("in_ready",  {31'd0, bus.in_ready},  {31'd0, exp_rdy});
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            check("result",     bus.result,              exp_res);
            check("zero",       {31'd0, bus.zero},       {31'd0, (exp_res == 32'd0)});
            check("illegal_op", {31'd0, bus.illegal_op}, {31'd0, exp_ill});
        end
        acc = iv && exp_rdy;
        ret = exp_valid && ordy;
        ref_op(c, a, b, r, ill);
        lat = latency(c, b);
        @(posedge clk);
        if (ret) exp_valid = 1'b0;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                exp_valid = 1'b1;
                exp_res   = pend_res;
                exp_ill   = 1'b0;
            end
        end
        if (acc) begin
            if (lat == 1) begin
                exp_valid = 1'b1;
                exp_res   = r;
                exp_ill   = ill;
            end else begin
                busy_cnt = lat - 1;
                pend_res = r;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'd0, 32'd0, 1'b1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_ctrl  = 4'h0;
        bus.src_a     = 32'd0;
        bus.src_b     = 32'd0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // ADD overflow wraps, latency 1
        step(1'b1, 4'h0, 32'h7FFF_FFFF, 32'd1, 1'b1);
        check("add_result", bus.result, 32'h8000_0000);
        check("add_valid",  {31'd0, bus.out_valid}, 32'd1);
        idle(1);

        // SUB to zero, SLT / SLTU with the same operands, back-to-back
        step(1'b1, 4'h1, 32'd5, 32'd5, 1'b1);
        check("sub_zero", {31'd0, bus.zero}, 32'd1);
        step(1'b1, 4'h4, 32'hFFFF_FFFF, 32'd1, 1'b1);
        check("slt_result", bus.result, 32'd1);
        step(1'b1, 4'h5, 32'hFFFF_FFFF, 32'd1, 1'b1);
        check("sltu_result", bus.result, 32'd0);
        idle(1);

        // SRA by 4 with sign replication
        step(1'b1, 4'h7, 32'h8000_0000, 32'd4, 1'b1);
        idle(FAST ? 0 : 4);
        check("sra_result", bus.result, 32'hF800_0000);
        idle(2);

        // XOR held by backpressure, then AND accepted on the retire cycle
        step(1'b1, 4'h6, 32'h0F0F_0F0F, 32'hFFFF_0000, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 4'hA, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1);
        check("and_result", bus.result, 32'h00F0_1234);
        idle(1);

        // illegal code, then a legal op clears the flag
        step(1'b1, 4'hF, 32'd123, 32'd456, 1'b1);
        check("illegal_flag", {31'd0, bus.illegal_op}, 32'd1);
        step(1'b1, 4'h9, 32'd1, 32'd2, 1'b1);
        check("illegal_clear", {31'd0, bus.illegal_op}, 32'd0);
        idle(1);

        // SLL by 31 interrupted by reset
        step(1'b1, 4'h3, 32'd1, 32'd31, 1'b1);
        idle(9);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(40);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit          iv;
            bit          ordy;
            logic [31:0] a;
            logic [31:0] b;
            logic [3:0]  c;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            c    = 4'($urandom_range(0, 15));
            a    = $urandom;
            b    = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
            step(iv, c, a, b, ordy);
        end
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
